// File: rtl/fir_csr_pkg.sv
// fir_csr_pkg: register map, status/control bit positions and launch FSM states for fir_csr_bank
package fir_csr_pkg;
  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_STATUS = 1;
  localparam int ADDR_COEF   = 2;
  localparam int ADDR_SAMP   = 3;
  localparam int ADDR_RUNS   = 4;
  localparam int START  = 0;
  localparam int IRQ_EN = 1;
  localparam int DONE   = 0;
  localparam int BUSY   = 1;
  localparam int ERR    = 2;
  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_RUN
  } state_t;
endpackage

// File: rtl/fir_csr_bank.sv
// fir_csr_bank: FIR control/status registers with start/busy/done launch FSM, sticky status, run counter and irq
module fir_csr_bank
  import fir_csr_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int COEF_W = 6,
  parameter int SAMP_W = 14,
  parameter int RUNS_W = 8
) (
  input  logic              clk_b,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              start_o,
  input  logic              core_busy_i,
  input  logic              core_done_i,
  output logic [COEF_W-1:0] coef_cnt_o,
  output logic [SAMP_W-1:0] samp_cnt_o,
  output logic              irq_o
);
  state_t            state, state_nx;
  logic              irq_en, done, err;
  logic [COEF_W-1:0] coef_reg;
  logic [SAMP_W-1:0] samp_reg;
  logic [RUNS_W-1:0] runs;
  logic              wr_ctrl, wr_stat, wr_coef, wr_samp;
  logic              idle, start_req, accept, done_evt, err_set;
  logic [DATA_W-1:0] ctrl_v, stat_v, rd_nx;
  logic              unused_wr_bits;

  assign unused_wr_bits = ^wr_data;

  // write decode and the launch/error/done events derived from it
  always_comb begin
    wr_ctrl   = wr_en && addr == ADDR_W'(ADDR_CTRL);
    wr_stat   = wr_en && addr == ADDR_W'(ADDR_STATUS);
    wr_coef   = wr_en && addr == ADDR_W'(ADDR_COEF);
    wr_samp   = wr_en && addr == ADDR_W'(ADDR_SAMP);
    idle      = state == S_IDLE;
    start_req = wr_ctrl && wr_data[START];
    accept    = start_req && idle && coef_reg != '0 && samp_reg != '0;
    done_evt  = core_done_i && (state == S_WAIT_BUSY || state == S_RUN);
    err_set   = (start_req && !accept) || ((wr_coef || wr_samp) && !idle) || (core_done_i && !done_evt);
  end

  // FSM state register
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM next state: a done pulse ends the run even before busy was seen
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:      state_nx = accept ? S_LAUNCH : S_IDLE;
      S_LAUNCH:    state_nx = S_WAIT_BUSY;
      S_WAIT_BUSY: state_nx = core_done_i ? S_IDLE : core_busy_i ? S_RUN : S_WAIT_BUSY;
      S_RUN:       state_nx = core_done_i ? S_IDLE : S_RUN;
      default:     state_nx = S_IDLE;
    endcase
  end

  // FSM outputs; irq is formed from registered bits only
  always_comb begin
    start_o = state == S_LAUNCH;
    irq_o   = done && irq_en;
  end

  // register file, launch snapshots and sticky status where a hardware set beats W1C
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      irq_en     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      coef_reg   <= '0;
      samp_reg   <= '0;
      coef_cnt_o <= '0;
      samp_cnt_o <= '0;
      runs       <= '0;
    end else begin
      if (wr_ctrl) irq_en <= wr_data[IRQ_EN];
      if (wr_coef && idle) coef_reg <= wr_data[COEF_W-1:0];
      if (wr_samp && idle) samp_reg <= wr_data[SAMP_W-1:0];
      if (accept) begin
        coef_cnt_o <= coef_reg;
        samp_cnt_o <= samp_reg;
      end
      if (done_evt) runs <= runs + RUNS_W'(1);
      done <= done_evt || (done && !accept && !(wr_stat && wr_data[DONE]));
      err  <= err_set || (err && !(wr_stat && wr_data[ERR]));
    end
  end

  // read mux over the current register contents
  always_comb begin
    ctrl_v         = '0;
    ctrl_v[IRQ_EN] = irq_en;
    stat_v         = '0;
    stat_v[DONE]   = done;
    stat_v[BUSY]   = !idle;
    stat_v[ERR]    = err;
    rd_nx = addr == ADDR_W'(ADDR_CTRL)   ? ctrl_v :
            addr == ADDR_W'(ADDR_STATUS) ? stat_v :
            addr == ADDR_W'(ADDR_COEF)   ? DATA_W'(coef_reg) :
            addr == ADDR_W'(ADDR_SAMP)   ? DATA_W'(samp_reg) :
            addr == ADDR_W'(ADDR_RUNS)   ? DATA_W'(runs) : '0;
  end

  // registered read port, one cycle of latency
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_nx;
  end
endmodule

// File: tb/tb_fir_csr_bank.sv
// tb_fir_csr_bank: scoreboard bench for fir_csr_bank against a register-level reference model
module tb_fir_csr_bank;
  logic        clk_b = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] wr_data = '0;
  logic [2:0]  addr = '0;
  logic        wr_en = 1'b0;
  logic [15:0] rd_data;
  logic        start_o;
  logic        core_busy_i = 1'b0;
  logic        core_done_i = 1'b0;
  logic [5:0]  coef_cnt_o;
  logic [13:0] samp_cnt_o;
  logic        irq_o;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rd_issue = 0;
  bit rd_vld = 0;
  bit fin = 0;
  logic [15:0] rd_q[$];
  int start_q[$];

  bit          m_irq_en, m_done, m_err, m_busy;
  logic [5:0]  m_coef, m_sc;
  logic [13:0] m_samp, m_ss;
  logic [7:0]  m_runs;

  fir_csr_bank dut (
    .clk_b(clk_b), .rst_n(rst_n), .wr_data(wr_data), .addr(addr), .wr_en(wr_en),
    .rd_data(rd_data), .start_o(start_o), .core_busy_i(core_busy_i),
    .core_done_i(core_done_i), .coef_cnt_o(coef_cnt_o), .samp_cnt_o(samp_cnt_o), .irq_o(irq_o)
  );

  always #5 clk_b = ~clk_b;

  always @(posedge clk_b) cyc <= cyc + 1;
  always @(posedge clk_b) rd_vld <= rd_issue;

  function automatic void mreset();
    m_irq_en = 0; m_done = 0; m_err = 0; m_busy = 0;
    m_coef = '0; m_samp = '0; m_sc = '0; m_ss = '0; m_runs = '0;
  endfunction

  function automatic logic [15:0] mread(input logic [2:0] a);
    case (a)
      3'd0: return {14'd0, m_irq_en, 1'b0};
      3'd1: return {13'd0, m_err, m_busy, m_done};
      3'd2: return {10'd0, m_coef};
      3'd3: return {2'd0, m_samp};
      3'd4: return {8'd0, m_runs};
      default: return 16'd0;
    endcase
  endfunction

  function automatic void mwrite(input logic [2:0] a, input logic [15:0] d);
    case (a)
      3'd0: begin
        m_irq_en = d[1];
        if (d[0]) begin
          if (!m_busy && m_coef != 0 && m_samp != 0) begin
            m_busy = 1; m_done = 0; m_sc = m_coef; m_ss = m_samp;
            start_q.push_back(cyc);
          end else m_err = 1;
        end
      end
      3'd1: begin
        if (d[0]) m_done = 0;
        if (d[2]) m_err = 0;
      end
      3'd2: if (m_busy) m_err = 1; else m_coef = d[5:0];
      3'd3: if (m_busy) m_err = 1; else m_samp = d[13:0];
      default: ;
    endcase
  endfunction

  function automatic void mdone();
    if (m_busy) begin
      m_done = 1; m_busy = 0; m_runs = m_runs + 8'd1;
    end else m_err = 1;
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endfunction

  // monitor: cycle-exact start pulses, outputs against the model, and queued reads
  always @(negedge clk_b) begin
    bit es;
    es = start_q.size() > 0 && start_q[0] == cyc;
    chk("start_o", int'(start_o), int'(es));
    if (es) void'(start_q.pop_front());
    chk("irq_o", int'(irq_o), int'(m_irq_en & m_done));
    chk("coef_cnt_o", int'(coef_cnt_o), int'(m_sc));
    chk("samp_cnt_o", int'(samp_cnt_o), int'(m_ss));
    if (rd_vld && rd_q.size() > 0) chk("rd_data", int'(rd_data), int'(rd_q.pop_front()));
    if (fin) begin
      chk("pending reads", rd_q.size(), 0);
      chk("missing start pulses", start_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  task automatic step(input bit we, input logic [2:0] a, input logic [15:0] d, input bit dn);
    wr_en = we; addr = a; wr_data = d; core_done_i = dn;
    @(posedge clk_b); #1;
    wr_en = 0; core_done_i = 0;
    if (we) mwrite(a, d);
    if (dn) mdone();
  endtask

  task automatic rd(input logic [2:0] a);
    addr = a; rd_issue = 1; rd_q.push_back(mread(a));
    @(posedge clk_b); #1;
    rd_issue = 0;
  endtask

  task automatic nstep(input bit noisy, input bit dn);
    if (noisy && $urandom_range(0, 2) == 0)
      step(1, 3'($urandom_range(0, 3)), 16'($urandom), dn);
    else
      step(0, 3'd0, 16'd0, dn);
  endtask

  task automatic core_run(input int wb, input int len, input bit noisy);
    nstep(noisy, 0);
    repeat (wb) nstep(noisy, 0);
    core_busy_i = 1;
    repeat (len) nstep(noisy, 0);
    core_busy_i = 0;
    nstep(noisy, 1);
  endtask

  task automatic run1(input int wb, input int len, input bit noisy);
    step(1, 3'd0, 16'h0003, 0);
    if (m_busy) core_run(wb, len, noisy);
  endtask

  initial begin
    mreset();
    repeat (3) @(posedge clk_b);
    #1 rst_n = 1;
    for (int i = 0; i < 8; i++) rd(3'(i));

    step(1, 3'd2, 16'h0020, 0);
    step(1, 3'd3, 16'h1000, 0);
    run1(0, 19, 0);
    rd(3'd1);
    rd(3'd4);
    step(1, 3'd1, 16'h0001, 0);
    rd(3'd1);

    step(1, 3'd0, 16'h0003, 0);
    nstep(0, 0);
    core_busy_i = 1;
    nstep(0, 0);
    step(1, 3'd2, 16'h0005, 0);
    step(1, 3'd0, 16'h0003, 0);
    rd(3'd2);
    rd(3'd1);
    core_busy_i = 0;
    nstep(0, 1);
    step(1, 3'd1, 16'h0004, 0);
    rd(3'd1);

    step(1, 3'd2, 16'h0000, 0);
    step(1, 3'd0, 16'h0001, 0);
    rd(3'd1);
    nstep(0, 0);
    step(1, 3'd1, 16'h0005, 0);
    step(1, 3'd2, 16'h0020, 0);
    step(1, 3'd0, 16'h0002, 0);

    step(1, 3'd0, 16'h0003, 0);
    nstep(0, 0);
    core_busy_i = 1;
    nstep(0, 0);
    core_busy_i = 0;
    step(1, 3'd1, 16'h0001, 1);
    rd(3'd1);

    repeat (256 - int'(m_runs)) run1(0, 1, 0);
    rd(3'd4);
    run1(1, 2, 0);
    rd(3'd4);

    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          step(1, 3'($urandom_range(0, 7)), 16'($urandom), 0);
          if (m_busy) core_run($urandom_range(0, 2), $urandom_range(0, 6), 1);
        end
        1: rd(3'($urandom_range(0, 7)));
        2: step(0, 3'd0, 16'd0, 1);
        default: begin
          if (m_coef == 0) step(1, 3'd2, 16'($urandom_range(1, 63)), 0);
          if (m_samp == 0) step(1, 3'd3, 16'($urandom_range(1, 16383)), 0);
          run1($urandom_range(0, 2), $urandom_range(0, 6), 1);
        end
      endcase
    end

    step(1, 3'd2, 16'h0011, 0);
    step(1, 3'd3, 16'h0222, 0);
    step(1, 3'd0, 16'h0003, 0);
    nstep(0, 0);
    core_busy_i = 1;
    repeat (3) nstep(0, 0);
    rst_n = 0;
    core_busy_i = 0;
    mreset();
    repeat (2) @(posedge clk_b);
    #1 rst_n = 1;
    for (int i = 0; i < 8; i++) rd(3'(i));
    step(1, 3'd2, 16'h0007, 0);
    step(1, 3'd3, 16'h0009, 0);
    run1(1, 4, 0);
    rd(3'd4);
    rd(3'd1);

    repeat (2) step(0, 3'd0, 16'd0, 0);
    fin = 1;
  end
endmodule
